// File: rtl/spi_master_seq.sv
// spi_master_seq: command-driven SPI master. Each accepted {op, payload} word is
// sent as one SS_n-framed MOSI transfer; read-data commands then wait out the
// slave turnaround and shift a MISO byte back, returned on a response strobe.
module spi_master_seq #(
  parameter int ADDR_SIZE = 8,
  parameter int RD_LAT    = 2,
  parameter int GAP       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_SIZE-1:0] cmd_data,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_data,
  output logic                 busy,
  output logic                 err_seq
);

  localparam int unsigned WW   = ADDR_SIZE + 2;
  localparam int unsigned CMAX = (WW > 15) ? WW : 15;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_SHIFT,
    S_WAIT,
    S_RECV,
    S_GAP
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [WW-1:0]        word;
  logic                 rd_op;
  logic                 addr_pend;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_load;
  logic                 cnt_done;
  logic                 accept;
  logic [ADDR_SIZE-2:0] rx;
  logic [ADDR_SIZE-1:0] rx_next;

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign cnt_done  = (cnt == '0);
  assign rx_next   = {rx, MISO};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and the counter reload value for the state being entered.
  always_comb begin
    state_next = state;
    cnt_load   = '0;
    case (state)
      S_IDLE: if (accept) state_next = S_SEL;
      S_SEL: begin
        state_next = S_SHIFT;
        cnt_load   = CW'(WW - 1);
      end
      S_SHIFT: if (cnt_done) begin
        if (rd_op) begin
          state_next = S_WAIT;
          cnt_load   = CW'(RD_LAT - 1);
        end else begin
          state_next = S_GAP;
          cnt_load   = CW'(GAP - 1);
        end
      end
      S_WAIT: if (cnt_done) begin
        state_next = S_RECV;
        cnt_load   = CW'(ADDR_SIZE - 1);
      end
      S_RECV: if (cnt_done) begin
        state_next = S_GAP;
        cnt_load   = CW'(GAP - 1);
      end
      S_GAP: if (cnt_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Serial pins decoded from state; reset forces the idle levels immediately.
  always_comb begin
    SS_n = 1'b1;
    MOSI = 1'b0;
    case (state)
      S_SEL, S_SHIFT: begin
        SS_n = 1'b0;
        MOSI = word[WW-1];
      end
      S_WAIT, S_RECV: SS_n = 1'b0;
      default: ;
    endcase
  end

  // Shared down-counter: reloaded on every state change, holds at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (state_next != state) cnt <= cnt_load;
    else if (!cnt_done)           cnt <= cnt - CW'(1);
  end

  // Command latch, MSB-first shift-out and read-sequence error tracking.
  // The word only shifts after SHIFT cycles, so SEL and the first SHIFT cycle
  // both present the opcode MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word      <= '0;
      rd_op     <= 1'b0;
      addr_pend <= 1'b0;
      err_seq   <= 1'b0;
    end else if (accept) begin
      word  <= {cmd_op, cmd_data};
      rd_op <= (cmd_op == 2'b11);
      if (cmd_op == 2'b10) begin
        addr_pend <= 1'b1;
      end else if (cmd_op == 2'b11) begin
        addr_pend <= 1'b0;
        if (!addr_pend) err_seq <= 1'b1;
      end
    end else if (state == S_SHIFT) begin
      word <= {word[WW-2:0], 1'b0};
    end
  end

  // MISO deserializer and one-cycle response strobe entering GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx        <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == S_RECV) begin
        rx <= rx_next[ADDR_SIZE-2:0];
        if (cnt_done) begin
          rsp_valid <= 1'b1;
          rsp_data  <= rx_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_seq.sv
// Self-checking bench for spi_master_seq: directed table, back-to-back,
// error-sequence, mid-frame reset and randomized commands against a model.
module tb_spi_master_seq;

  localparam int AW = 8;
  localparam int RL = 2;
  localparam int GP = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_data = '0;
  logic          MISO = 1'b0;
  logic          cmd_ready, SS_n, MOSI, rsp_valid, busy, err_seq;
  logic [AW-1:0] rsp_data;

  int passed = 0;
  int total  = 0;
  bit pend_m = 0;
  bit err_m  = 0;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] data;
    logic [AW-1:0] miso;
    int            len;
    logic [AW+2:0] mosi;
    int            rsp_n;
    logic [AW-1:0] rsp;
    int            lat;
  } vec_t;

  vec_t tv[4];

  always #5 clk = ~clk;

  spi_master_seq #(.ADDR_SIZE(AW), .RD_LAT(RL), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err_seq(err_seq)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference model: frame length, MOSI bit sequence and read-sequence error.
  function automatic int m_len(input logic [1:0] op);
    return (op == 2'b11) ? (2 * AW + 3 + RL) : (AW + 3);
  endfunction

  function automatic logic [AW+2:0] m_mosi(input logic [1:0] op, input logic [AW-1:0] d);
    logic [AW+1:0] w;
    w = {op, d};
    return {w[AW+1], w};
  endfunction

  task automatic m_accept(input logic [1:0] op);
    if (op == 2'b11) begin
      if (!pend_m) err_m = 1;
      pend_m = 0;
    end else if (op == 2'b10) begin
      pend_m = 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    MISO = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pend_m = 0;
    err_m = 0;
  endtask

  // Issue one command and observe its whole frame, one sample per negedge.
  task automatic do_frame(input logic [1:0] op, input logic [AW-1:0] data,
                          input logic [AW-1:0] miso_byte, input bit poke,
                          output int len, output logic [AW+2:0] mb, output int rc,
                          output logic [AW-1:0] rv, output int lat,
                          output bit busy_ok, output bit tail_ok);
    int w, i, j;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("ready_wait", 32'd0, 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    len = 0; mb = '0; rc = 0; rv = '0; lat = -1; busy_ok = 1; tail_ok = 1;
    for (i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        lat = i;
        break;
      end
      if (!busy) busy_ok = 0;
      if (!SS_n) len++;
      if (i < AW + 3) mb = {mb[AW+1:0], MOSI};
      else if (MOSI) tail_ok = 0;
      if (rsp_valid) begin
        rc++;
        rv = rsp_data;
      end
      j = i - (AW + 3 + RL);
      MISO = (j >= 0 && j < AW) ? miso_byte[AW-1-j] : 1'b0;
      if (poke) begin
        cmd_valid = (i == 3);
        cmd_op = ~op;
        cmd_data = ~data;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    MISO = 1'b0;
  endtask

  int len, rc, lat, nrsp, nlow;
  logic [AW+2:0] mb;
  logic [AW-1:0] rv;
  bit bok, tok;

  // Back-to-back section state
  logic [1:0]    bop[4];
  logic [AW-1:0] bdat[4];
  logic [AW-1:0] bmiso;
  int idx, fi, high_run, low_run, nfall, j2, bexp;
  int gaps[3];
  int lows[4];
  int accs[4];
  bit acc, prev_ss;

  initial begin
    tv[0] = '{2'b00, 8'hA5, 8'h00, 11, 11'b00010100101, 0, 8'h00, 12};
    tv[1] = '{2'b10, 8'h3C, 8'h00, 11, 11'b11000111100, 0, 8'h00, 12};
    tv[2] = '{2'b11, 8'h00, 8'hC3, 21, 11'b11100000000, 1, 8'hC3, 22};
    tv[3] = '{2'b01, 8'h5A, 8'h00, 11, 11'b00101011010, 0, 8'h00, 12};

    // Reset values
    @(negedge clk);
    check("rst_ss_n", SS_n, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_seq, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", cmd_ready, 1);

    // Directed table
    for (int t = 0; t < 4; t++) begin
      do_frame(tv[t].op, tv[t].data, tv[t].miso, 0, len, mb, rc, rv, lat, bok, tok);
      check($sformatf("tbl%0d_len", t), len, tv[t].len);
      check($sformatf("tbl%0d_mosi", t), mb, tv[t].mosi);
      check($sformatf("tbl%0d_rsp_n", t), rc, tv[t].rsp_n);
      if (tv[t].rsp_n > 0) check($sformatf("tbl%0d_rsp", t), rv, tv[t].rsp);
      check($sformatf("tbl%0d_lat", t), lat, tv[t].lat);
      check($sformatf("tbl%0d_busy", t), bok, 1);
      check($sformatf("tbl%0d_tail", t), tok, 1);
      check($sformatf("tbl%0d_err", t), err_seq, 0);
    end

    // Back-to-back with cmd_valid held high
    bop[0] = 2'b00; bop[1] = 2'b01; bop[2] = 2'b10; bop[3] = 2'b11;
    bdat[0] = 8'h11; bdat[1] = 8'h22; bdat[2] = 8'h33; bdat[3] = 8'h44;
    bmiso = 8'h96;
    idx = 0; acc = 0; fi = 0; high_run = 0; low_run = 0; nfall = 0; rc = 0; rv = '0;
    prev_ss = 1;
    for (int k = 0; k < 4; k++) begin lows[k] = -1; accs[k] = -1; end
    for (int k = 0; k < 3; k++) gaps[k] = -1;
    cmd_valid = 1'b1; cmd_op = bop[0]; cmd_data = bdat[0];
    for (int c = 0; c < 300; c++) begin
      if (!SS_n) begin
        if (prev_ss && nfall < 4) begin
          if (nfall > 0) gaps[nfall-1] = high_run;
          nfall++;
          low_run = 0;
        end
        low_run++;
      end else begin
        if (!prev_ss && nfall > 0) lows[nfall-1] = low_run;
        high_run = prev_ss ? high_run + 1 : 1;
      end
      prev_ss = SS_n;
      if (rsp_valid) begin rc++; rv = rsp_data; end
      j2 = fi - (AW + 3 + RL);
      MISO = (idx == 4 && j2 >= 0 && j2 < AW) ? bmiso[AW-1-j2] : 1'b0;
      if (cmd_valid && cmd_ready) begin
        accs[idx] = c;
        acc = 1;
      end else if (idx == 4 && cmd_ready) begin
        break;
      end
      @(negedge clk);
      if (acc) begin
        idx++; acc = 0; fi = 0;
        if (idx < 4) begin cmd_op = bop[idx]; cmd_data = bdat[idx]; end
        else cmd_valid = 1'b0;
      end else begin
        fi++;
      end
    end
    cmd_valid = 1'b0;
    MISO = 1'b0;
    check("b2b_accepts", idx, 4);
    check("b2b_frames", nfall, 4);
    for (int k = 0; k < 3; k++) check($sformatf("b2b_gap%0d", k), gaps[k], GP + 1);
    for (int k = 0; k < 4; k++) check($sformatf("b2b_low%0d", k), lows[k], m_len(bop[k]));
    for (int k = 0; k < 3; k++) begin
      bexp = m_len(bop[k]) + GP + 1;
      check($sformatf("b2b_spacing%0d", k), accs[k+1] - accs[k], bexp);
    end
    check("b2b_rsp_n", rc, 1);
    check("b2b_rsp", rv, bmiso);

    // Read-data without a preceding read-addr
    do_reset();
    do_frame(2'b11, 8'h00, 8'h5E, 0, len, mb, rc, rv, lat, bok, tok);
    check("err_first_flag", err_seq, 1);
    check("err_first_len", len, 21);
    check("err_first_rsp_n", rc, 1);
    check("err_first_rsp", rv, 8'h5E);
    do_frame(2'b10, 8'h12, 8'h00, 0, len, mb, rc, rv, lat, bok, tok);
    do_frame(2'b11, 8'h34, 8'h81, 0, len, mb, rc, rv, lat, bok, tok);
    check("err_sticky", err_seq, 1);
    check("err_pair_rsp", rv, 8'h81);

    // Reset in the 5th SHIFT cycle of a read-data frame
    do_reset();
    do_frame(2'b10, 8'h3C, 8'h00, 0, len, mb, rc, rv, lat, bok, tok);
    do_frame(2'b11, 8'h00, 8'hA7, 0, len, mb, rc, rv, lat, bok, tok);
    check("mid_pre_rsp", rsp_data, 8'hA7);
    check("mid_pre_err", err_seq, 0);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'h5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_ss_low", SS_n, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_ss_n", SS_n, 1);
    check("mid_mosi", MOSI, 0);
    check("mid_rsp_data", rsp_data, 0);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_ready", cmd_ready, 0);
    nrsp = 0; nlow = 0;
    repeat (3) begin @(negedge clk); if (rsp_valid) nrsp++; end
    rst = 1'b0; pend_m = 0; err_m = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
      if (!SS_n) nlow++;
    end
    check("mid_no_rsp", nrsp, 0);
    check("mid_no_frame", nlow, 0);
    do_frame(2'b00, 8'hA5, 8'h00, 0, len, mb, rc, rv, lat, bok, tok);
    check("post_rst_mosi", mb, 11'b00010100101);
    check("post_rst_len", len, 11);
    check("post_rst_lat", lat, 12);

    // Command pulsed while busy must be ignored
    do_frame(2'b01, 8'h33, 8'h00, 1, len, mb, rc, rv, lat, bok, tok);
    check("poke_mosi", mb, 11'b00100110011);
    check("poke_len", len, 11);
    nlow = 0;
    repeat (4) begin @(negedge clk); if (!SS_n) nlow++; end
    check("poke_no_extra", nlow, 0);

    // Randomized commands against the model
    for (int n = 0; n < 24; n++) begin
      logic [1:0]    rop;
      logic [AW-1:0] rdat, rmiso;
      bit            rpoke;
      rop = 2'($urandom_range(0, 3));
      rdat = AW'($urandom);
      rmiso = AW'($urandom);
      rpoke = 1'($urandom_range(0, 1));
      m_accept(rop);
      do_frame(rop, rdat, rmiso, rpoke, len, mb, rc, rv, lat, bok, tok);
      check($sformatf("rnd%0d_len", n), len, m_len(rop));
      check($sformatf("rnd%0d_mosi", n), mb, m_mosi(rop, rdat));
      check($sformatf("rnd%0d_rsp_n", n), rc, (rop == 2'b11) ? 1 : 0);
      if (rop == 2'b11) check($sformatf("rnd%0d_rsp", n), rv, rmiso);
      check($sformatf("rnd%0d_lat", n), lat, m_len(rop) + GP);
      check($sformatf("rnd%0d_err", n), err_seq, err_m);
      check($sformatf("rnd%0d_busy", n), bok, 1);
      check($sformatf("rnd%0d_tail", n), tok, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
